image_dram_reader: RTL and testbench
====================================

// Module: image_dram_reader
// PURPOSE
//  AXI4 read master that streams a frame buffer from PL DDR4 to the HDMI pixel path.
//  Sits between the image controller registers (frame start/end address) and the pixel FIFO.
//  Fetches [frame_start_addr, frame_end_addr) in fixed INCR bursts, one burst outstanding.
//  Emits beats on an AXI4-Stream with SOF (tuser) and EOF (tlast) markers.
// PARAMETERS
//  ADDR_WIDTH   64   AXI address width; frame addresses are byte addresses (e.g. 0x4_0000_0000)
//  DATA_WIDTH   128  AXI/stream data width; BEAT_BYTES = DATA_WIDTH/8 = 16
//  BURST_LEN    16   beats per burst (1..256); BURST_BYTES = BURST_LEN*BEAT_BYTES = 256
// PORTS
//  m_axi_aclk         in   1           single clock for all logic
//  m_axi_aresetn      in   1           asynchronous active-low reset
//  start              in   1           1-cycle pulse: begin a frame (ignored while busy)
//  stop               in   1           level: finish current burst, then return to IDLE
//  auto_restart       in   1           1: loop frames back-to-back; sampled at frame end
//  frame_start_addr   in   ADDR_WIDTH  first byte; latched on accepted start
//  frame_end_addr     in   ADDR_WIDTH  one past last byte (exclusive); latched on accepted start
//  busy               out  1           1 in any state other than IDLE
//  frame_done         out  1           1-cycle pulse when last beat of a frame leaves the stream
//  error              out  1           sticky: bad addresses or RRESP!=OKAY; cleared by accepted start
//  m_axi_araddr       out  ADDR_WIDTH  burst address
//  m_axi_arlen        out  8           constant BURST_LEN-1
//  m_axi_arsize       out  3           constant log2(BEAT_BYTES)
//  m_axi_arburst      out  2           constant 2'b01 (INCR)
//  m_axi_arcache      out  4           constant 4'b0011
//  m_axi_arprot       out  3           constant 3'b000
//  m_axi_arvalid      out  1           AR valid
//  m_axi_arready      in   1           AR ready
//  m_axi_rdata        in   DATA_WIDTH  read data
//  m_axi_rresp        in   2           read response
//  m_axi_rlast        in   1           last beat of burst
//  m_axi_rvalid       in   1           R valid
//  m_axi_rready       out  1           R ready
//  m_axis_tdata       out  DATA_WIDTH  pixel beat
//  m_axis_tvalid      out  1           stream valid
//  m_axis_tready      in   1           stream ready
//  m_axis_tuser       out  1           1 on first beat of frame (SOF)
//  m_axis_tlast       out  1           1 on last beat of frame (EOF)
// BEHAVIOUR
//  Reset: all outputs 0 (arvalid, rready, tvalid, busy, frame_done, error, araddr, tdata); state IDLE.
//  States: IDLE -> ADDR -> DATA -> (ADDR | IDLE).
//   IDLE: on start: latch addrs, clear error; if start%BURST_BYTES!=0, end%BURST_BYTES!=0
//         or end<=start -> set error, stay IDLE; else cur_addr=start, go ADDR.
//   ADDR: arvalid=1, araddr=cur_addr held stable until arready; on handshake -> DATA.
//   DATA: accept R beats; on rlast handshake cur_addr+=BURST_BYTES, then:
//         cur_addr==end & auto_restart & !stop -> cur_addr=start, ADDR (next frame);
//         cur_addr==end otherwise or stop==1 -> IDLE; else -> ADDR.
//  Output stage: one register slot; m_axi_rready = !m_axis_tvalid | m_axis_tready (in DATA only).
//   No combinational path tready->tvalid; full throughput when tready held 1.
//  tuser=1 on first beat after frame (re)start; tlast=1 on beat of final burst with rlast.
//  frame_done pulses the cycle the tlast beat handshakes on the stream; not on stop abort.
//  Stop mid-frame: current burst drained fully (no dangling R beats), no tlast emitted, IDLE.
//  RRESP!=0: error set, beat still forwarded, frame continues (display must not stall).
//  busy stays 1 until the registered stream slot is empty after returning to IDLE.
//  Address arithmetic modulo 2^ADDR_WIDTH; aligned bursts never cross a 4 KB boundary.
//  Async reset mid-burst: everything returns to reset values immediately; no drain.
// TESTING
//  start=0x4_0000_0000,end=0x4_0000_0400,tready=1 -> 4 ARs at +0x000/+0x100/+0x200/+0x300,
//   64 beats, tuser on beat 0, tlast on beat 63, one frame_done, busy falls after.
//  Same frame, tready toggled 1/0 each cycle -> data order intact, no beat lost or duplicated.
//  auto_restart=1, end=start+0x200 -> 2nd frame ARs restart at start, tuser on beat 32.
//  stop asserted during burst 2 of 4 -> burst 2 completes (16 beats), no AR 3, no tlast/done.
//  start=0x4_0000_0010 (misaligned) -> error=1, no arvalid, busy=0; next valid start clears error.
//  rresp=2'b10 on one beat -> error=1, all 64 beats still emitted, frame_done pulses.

Source files
------------

// File: rtl/image_dram_reader.sv
// image_dram_reader: AXI4 burst read master streaming a frame buffer onto AXI4-Stream with SOF/EOF markers.
module image_dram_reader #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128,
  parameter int BURST_LEN  = 16
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_restart,
  input  logic [ADDR_WIDTH-1:0] frame_start_addr,
  input  logic [ADDR_WIDTH-1:0] frame_end_addr,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast
);
  localparam int BEAT_BYTES  = DATA_WIDTH / 8;
  localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam int OFS         = $clog2(BURST_BYTES);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] start_addr, end_addr, cur_addr, next_addr;
  logic sof, r_hs, t_hs, last_burst, bad;
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'($clog2(BEAT_BYTES));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_araddr  = cur_addr;
  assign m_axi_arvalid = state == ADDR;
  // The single output slot accepts a new beat whenever it is empty or draining this cycle.
  assign m_axi_rready  = (state == DATA) && (!m_axis_tvalid || m_axis_tready);
  assign r_hs          = m_axi_rvalid && m_axi_rready;
  assign t_hs          = m_axis_tvalid && m_axis_tready;
  assign next_addr     = cur_addr + ADDR_WIDTH'(BURST_BYTES);
  assign last_burst    = next_addr == end_addr;
  assign busy          = (state != IDLE) || m_axis_tvalid;
  assign frame_done    = t_hs && m_axis_tlast;
  assign bad           = (|frame_start_addr[OFS-1:0]) || (|frame_end_addr[OFS-1:0]) ||
                         (frame_end_addr <= frame_start_addr);
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state         <= IDLE;
      start_addr    <= '0;
      end_addr      <= '0;
      cur_addr      <= '0;
      sof           <= 1'b0;
      error         <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (t_hs) m_axis_tvalid <= 1'b0;
      if (r_hs) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= m_axi_rdata;
        m_axis_tuser  <= sof;
        m_axis_tlast  <= m_axi_rlast && last_burst;
        sof           <= 1'b0;
        if (m_axi_rresp != 2'b00) error <= 1'b1;
      end
      case (state)
        IDLE: if (start && !m_axis_tvalid) begin
          start_addr <= frame_start_addr;
          end_addr   <= frame_end_addr;
          cur_addr   <= frame_start_addr;
          sof        <= 1'b1;
          error      <= bad;
          state      <= bad ? IDLE : ADDR;
        end
        ADDR: if (m_axi_arready) state <= DATA;
        DATA: if (r_hs && m_axi_rlast) begin
          if (last_burst && auto_restart && !stop) begin
            cur_addr <= start_addr;
            sof      <= 1'b1;
            state    <= ADDR;
          end else begin
            cur_addr <= next_addr;
            state    <= (last_burst || stop) ? IDLE : ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_image_dram_reader.sv
// tb_image_dram_reader: randomized AXI slave + stream sink with a frame-level reference model and scoreboard.
module tb_image_dram_reader;
  localparam int AW = 64, DW = 128, BL = 16, BB = 256;
  localparam logic [AW-1:0] S = 64'h4_0000_0000;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic start = 0, stop = 0, auto_restart = 0;
  logic [AW-1:0] fsa = '0, fea = '0;
  logic busy, frame_done, error;
  logic [AW-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst, rresp = 0;
  logic [3:0] arcache;
  logic arvalid, arready = 0, rlast = 0, rvalid = 0, rready;
  logic [DW-1:0] rdata = '0, tdata;
  logic tvalid, tready = 0, tuser, tlast;

  image_dram_reader dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .start(start), .stop(stop), .auto_restart(auto_restart),
    .frame_start_addr(fsa), .frame_end_addr(fea), .busy(busy), .frame_done(frame_done), .error(error),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
    .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast)
  );

  typedef struct packed {logic [DW-1:0] d; logic u; logic l;} beat_t;
  beat_t exp_q[$];
  logic [AW-1:0] exp_ar[$];
  logic [AW-1:0] bursts[$];
  int checks = 0, errors = 0, done_exp = 0, done_seen = 0, ar_seen = 0;
  int tmode = 0, inject = -1, gbeat = 0, beat = 0;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return {a ^ 64'hA5A5_5A5A_F00D_CAFE, a};
  endfunction

  task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Expected ARs and beats for the first `keep` bursts of an nb-burst frame at s.
  task automatic push_frame(input logic [AW-1:0] s, input int nb, input int keep);
    for (int i = 0; i < keep; i++) exp_ar.push_back(s + AW'(i * BB));
    for (int k = 0; k < keep * BL; k++)
      exp_q.push_back('{d: mem(s + AW'(k * 16)), u: k == 0, l: (keep == nb) && (k == nb * BL - 1)});
    if (keep == nb) done_exp++;
  endtask

  task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] e);
    @(posedge clk); #1;
    fsa = s; fea = e; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_ar(input int target);
    int n;
    n = 0;
    while (ar_seen < target && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ar_wait_timeout", DW'(n < 5000), DW'(1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) @(posedge clk);
    #1;
    while ((busy || exp_q.size() != 0) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", DW'(n < 5000), DW'(1));
    chk("busy_low", DW'(busy), DW'(0));
    chk("beats_left", DW'(exp_q.size()), DW'(0));
    chk("ars_left", DW'(exp_ar.size()), DW'(0));
    chk("frame_done_count", DW'(done_seen), DW'(done_exp));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a handshake.
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (rst_n && tvalid && tready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got %0h expected none", tdata);
      end else begin
        e = exp_q.pop_front();
        chk("tdata", tdata, e.d);
        chk("tuser", DW'(tuser), DW'(e.u));
        chk("tlast", DW'(tlast), DW'(e.l));
      end
    end
    if (rst_n && arvalid && arready) begin
      ar_seen++;
      chk("ar_consts", DW'({arlen, arsize, arburst, arcache, arprot}), DW'({8'd15, 3'd4, 2'b01, 4'b0011, 3'b000}));
      if (exp_ar.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ar: got %0h expected none", araddr);
      end else chk("araddr", DW'(araddr), DW'(exp_ar.pop_front()));
    end
    if (frame_done) done_seen++;
  end

  // AXI read slave and stream sink; handshakes sampled mid-cycle, inputs driven just after the edge.
  initial forever begin
    logic arh, rh;
    logic [AW-1:0] cap;
    @(negedge clk);
    arh = arvalid && arready;
    rh = rvalid && rready;
    cap = araddr;
    @(posedge clk); #1;
    if (arh) bursts.push_back(cap);
    if (rh) begin
      gbeat++;
      if (beat == BL - 1) begin
        beat = 0;
        void'(bursts.pop_front());
      end else beat++;
    end
    arready = $urandom_range(0, 2) != 0;
    if (!(rvalid && !rh)) begin
      if (bursts.size() > 0 && $urandom_range(0, 3) != 0) begin
        rvalid = 1;
        rdata = mem(bursts[0] + AW'(beat * 16));
        rlast = beat == BL - 1;
        rresp = (gbeat == inject) ? 2'b10 : 2'b00;
      end else rvalid = 0;
    end
    tready = (tmode == 0) ? 1'b1 : (tmode == 1) ? ~tready : 1'($urandom_range(0, 1));
  end

  initial begin
    logic [AW-1:0] s;
    int nb, base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", DW'({arvalid, rready, tvalid, busy, frame_done, error}), DW'(0));
    chk("rst_araddr", DW'(araddr), DW'(0));
    chk("rst_tdata", tdata, DW'(0));
    rst_n = 1;
    // Full-rate frame of 4 bursts, with a start pulse while busy that must be ignored.
    tmode = 0;
    push_frame(S, 4, 4);
    do_start(S, S + 64'h400);
    repeat (20) @(posedge clk);
    do_start(S + 64'h10, S + 64'h400);
    wait_idle();
    chk("no_error_t1", DW'(error), DW'(0));
    // Same frame with toggling backpressure.
    tmode = 1;
    push_frame(S, 4, 4);
    do_start(S, S + 64'h400);
    wait_idle();
    // Auto-restart: two back-to-back 2-burst frames.
    tmode = 2;
    auto_restart = 1;
    base = ar_seen;
    push_frame(S, 2, 2);
    push_frame(S, 2, 2);
    do_start(S, S + 64'h200);
    wait_ar(base + 3);
    auto_restart = 0;
    wait_idle();
    // Stop during burst 2 of 4: burst drained, no EOF, no frame_done.
    base = ar_seen;
    push_frame(S, 4, 2);
    do_start(S, S + 64'h400);
    wait_ar(base + 2);
    stop = 1;
    wait_idle();
    stop = 0;
    // Address validation.
    do_start(S + 64'h10, S + 64'h400);
    repeat (3) @(posedge clk);
    #1;
    chk("mis_start_error", DW'(error), DW'(1));
    chk("mis_start_busy", DW'(busy), DW'(0));
    chk("mis_start_arvalid", DW'(arvalid), DW'(0));
    do_start(S, S + 64'h410);
    repeat (3) @(posedge clk);
    #1;
    chk("mis_end_error", DW'(error), DW'(1));
    do_start(S + 64'h400, S + 64'h400);
    repeat (3) @(posedge clk);
    #1;
    chk("empty_error", DW'({error, busy}), DW'(2'b10));
    push_frame(S + 64'h1000, 1, 1);
    do_start(S + 64'h1000, S + 64'h1100);
    chk("error_cleared", DW'(error), DW'(0));
    wait_idle();
    // Bad RRESP on one beat: flagged but the frame still completes.
    inject = gbeat + 17;
    push_frame(S, 4, 4);
    do_start(S, S + 64'h400);
    wait_idle();
    chk("rresp_error", DW'(error), DW'(1));
    inject = -1;
    // Randomized frames.
    for (int i = 0; i < 8; i++) begin
      s = S + AW'($urandom_range(0, 4095)) * 256;
      nb = $urandom_range(1, 5);
      tmode = $urandom_range(0, 2);
      push_frame(s, nb, nb);
      do_start(s, s + AW'(nb * BB));
      wait_idle();
      chk("rand_error", DW'(error), DW'(0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
